// File: rtl/irq_encoder_pkg.sv
// Shared types and defaults for the irq_encoder block: FSM state encoding
// and the default request-line count and synchronizer depth.
package irq_encoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } irq_state_e;

    localparam int DEF_N_REQ       = 8;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/irq_encoder_if.sv
// Code/valid/ack handshake between the encoder (master) and the consumer
// of the presented interrupt index (slave).
interface irq_encoder_if #(
    parameter int IDX_W = 3
) ();

    logic [IDX_W-1:0] code;
    logic             valid;
    logic             ack;

    modport master (
        output code,
        output valid,
        input  ack
    );

    modport slave (
        input  code,
        input  valid,
        output ack
    );

endinterface

// File: rtl/irq_encoder_prio_enc_148.sv
// Combinational highest-index-wins priority encoder, the core of the
// LS148-style cascade used by irq_encoder.
module prio_enc_148 #(
    parameter int N_REQ = 8,
    localparam int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Ascending scan: the last set bit visited is the highest index.
    always_comb begin
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_vec_i[i]) begin
                idx_o = IDX_W'(i);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_encoder.sv
// Registered interrupt priority encoder: synchronizes active-low requests,
// latches falling edges into a pending bitmap and presents the highest
// pending index over a valid/ack handshake. Optional per-line masking is
// enabled by defining IRQ_ENCODER_MASK_EN.
module irq_encoder
    import irq_encoder_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    localparam int IDX_W      = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_n,
    input  logic             ei_n,
`ifdef IRQ_ENCODER_MASK_EN
    input  logic [N_REQ-1:0] mask,
`endif
    irq_encoder_if.master    irq,
    output logic             gs_n,
    output logic             eo_n,
    output logic [N_REQ-1:0] pending
);

    logic [N_REQ-1:0] sync_q [SYNC_STAGES];
    logic [N_REQ-1:0] prev_q;
    logic [N_REQ-1:0] fall;
    logic [N_REQ-1:0] pending_q;
    logic [N_REQ-1:0] pending_d;
    logic [N_REQ-1:0] clr;
    logic [N_REQ-1:0] sel;
    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    irq_state_e       state_q;
    logic [IDX_W-1:0] code_q;
    logic             valid_q;

    function automatic logic [N_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] i);
        idx_onehot    = '0;
        idx_onehot[i] = 1'b1;
    endfunction

    // Request lines are asynchronous; idle level is high, so reset to all-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '1;
            end
            prev_q <= '1;
        end else begin
            sync_q[0] <= req_n;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = prev_q & ~sync_q[SYNC_STAGES-1];

    always_comb begin
        clr = '0;
        if (state_q == ST_PRESENT && irq.ack) begin
            clr = idx_onehot(code_q);
        end
    end

    // OR-ing the new edges in after the clear lets a fresh edge win a collision.
    always_comb begin
        pending_d = (pending_q & ~clr) | fall;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef IRQ_ENCODER_MASK_EN
    assign sel = pending_q & mask;
`else
    assign sel = pending_q;
`endif

    prio_enc_148 #(
        .N_REQ (N_REQ)
    ) u_enc (
        .req_vec_i (sel),
        .idx_o     (enc_idx),
        .any_o     (enc_any)
    );

    // Cascade outputs stay combinational so chained encoders see no FSM delay.
    assign gs_n = ~enc_any;
    assign eo_n = ei_n | enc_any;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            code_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!ei_n && enc_any) begin
                        code_q  <= enc_idx;
                        valid_q <= 1'b1;
                        state_q <= ST_PRESENT;
                    end
                end
                // Presentation is locked until ack; no preemption, ei_n ignored.
                ST_PRESENT: begin
                    if (irq.ack) begin
                        valid_q <= 1'b0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq.code  = code_q;
    assign irq.valid = valid_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_encoder.sv
// Directed self-checking bench for irq_encoder: reset, capture latency,
// priority, no-preemption, enable blocking, set/clear collision and masking.
module tb_irq_encoder;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_n;
    logic       ei_n;
    logic       gs_n;
    logic       eo_n;
    logic [7:0] pending;
`ifdef IRQ_ENCODER_MASK_EN
    logic [7:0] mask_v;
`endif

    int n_cmp;
    int n_bad;

    irq_encoder_if #(.IDX_W(3)) irq ();

    irq_encoder #(
        .N_REQ       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_n   (req_n),
        .ei_n    (ei_n),
`ifdef IRQ_ENCODER_MASK_EN
        .mask    (mask_v),
`endif
        .irq     (irq.master),
        .gs_n    (gs_n),
        .eo_n    (eo_n),
        .pending (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack();
        irq.ack = 1'b1;
        step(1);
        irq.ack = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        req_n   = 8'hFF;
        ei_n    = 1'b0;
        irq.ack = 1'b0;
`ifdef IRQ_ENCODER_MASK_EN
        mask_v  = 8'hFF;
`endif
        #2;
        chk("rst_valid",   32'(irq.valid), 32'h0);
        chk("rst_code",    32'(irq.code),  32'h0);
        chk("rst_pending", 32'(pending),   32'h0);
        chk("rst_gs_n",    32'(gs_n),      32'h1);
        chk("rst_eo_n_lo", 32'(eo_n),      32'h0);
        ei_n = 1'b1;
        #1;
        chk("rst_eo_n_hi", 32'(eo_n),      32'h1);
        ei_n = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("idle_pending", 32'(pending), 32'h0);

        // Single request on line 5: pending at k+2, valid after k+3.
        req_n = 8'hDF;
        step(1);
        chk("single_pend_k",  32'(pending),   32'h00);
        step(1);
        chk("single_pend_k1", 32'(pending),   32'h00);
        step(1);
        chk("single_pend_k2", 32'(pending),   32'h20);
        chk("single_vld_k2",  32'(irq.valid), 32'h0);
        chk("single_gs_n",    32'(gs_n),      32'h0);
        step(1);
        chk("single_vld_k3",  32'(irq.valid), 32'h1);
        chk("single_code",    32'(irq.code),  32'h5);
        do_ack();
        chk("single_ack_vld",  32'(irq.valid), 32'h0);
        chk("single_ack_pend", 32'(pending),   32'h00);
        chk("single_ack_gs_n", 32'(gs_n),      32'h1);
        chk("single_ack_eo_n", 32'(eo_n),      32'h0);
        step(3);
        chk("held_low_pend", 32'(pending),   32'h00);
        chk("held_low_vld",  32'(irq.valid), 32'h0);
        req_n = 8'hFF;
        step(3);

        // Lines 6 and 2 together: 6 first, two low cycles, then 2.
        req_n = 8'hBB;
        step(4);
        chk("prio_vld1",  32'(irq.valid), 32'h1);
        chk("prio_code1", 32'(irq.code),  32'h6);
        chk("prio_pend1", 32'(pending),   32'h44);
        do_ack();
        chk("prio_gap_vld",  32'(irq.valid), 32'h0);
        chk("prio_gap_pend", 32'(pending),   32'h04);
        step(1);
        chk("prio_idle_vld", 32'(irq.valid), 32'h0);
        step(1);
        chk("prio_vld2",  32'(irq.valid), 32'h1);
        chk("prio_code2", 32'(irq.code),  32'h2);
        do_ack();
        req_n = 8'hFF;
        step(3);

        // Line 7 arriving while line 1 is presented must not preempt.
        req_n = 8'hFD;
        step(4);
        chk("nopre_code1", 32'(irq.code), 32'h1);
        req_n = 8'h7D;
        step(4);
        chk("nopre_hold_code", 32'(irq.code),  32'h1);
        chk("nopre_hold_vld",  32'(irq.valid), 32'h1);
        chk("nopre_hold_pend", 32'(pending),   32'h82);
        do_ack();
        step(2);
        chk("nopre_vld7",  32'(irq.valid), 32'h1);
        chk("nopre_code7", 32'(irq.code),  32'h7);
        do_ack();
        req_n = 8'hFF;
        step(3);

        // Enable blocking: latched but not presented while ei_n is high.
        ei_n  = 1'b1;
        req_n = 8'hF7;
        step(4);
        chk("en_pend", 32'(pending),   32'h08);
        chk("en_gs_n", 32'(gs_n),      32'h0);
        chk("en_eo_n", 32'(eo_n),      32'h1);
        chk("en_vld",  32'(irq.valid), 32'h0);
        ei_n = 1'b0;
        step(1);
        chk("en_release_vld",  32'(irq.valid), 32'h1);
        chk("en_release_code", 32'(irq.code),  32'h3);
        ei_n = 1'b1;
        step(2);
        chk("en_ignored_vld", 32'(irq.valid), 32'h1);
        do_ack();
        chk("en_ack_vld",  32'(irq.valid), 32'h0);
        chk("en_ack_pend", 32'(pending),   32'h00);
        chk("en_ack_eo_n", 32'(eo_n),      32'h1);
        ei_n  = 1'b0;
        req_n = 8'hFF;
        step(3);

        // New edge on line 4 lands on the same clock as the ack of code 4.
        req_n = 8'hEF;
        step(4);
        chk("coll_code1", 32'(irq.code), 32'h4);
        req_n = 8'hFF;
        step(3);
        req_n = 8'hEF;
        step(2);
        irq.ack = 1'b1;
        step(1);
        irq.ack = 1'b0;
        chk("coll_pend", 32'(pending),   32'h10);
        chk("coll_vld",  32'(irq.valid), 32'h0);
        step(2);
        chk("coll_vld2",  32'(irq.valid), 32'h1);
        chk("coll_code2", 32'(irq.code),  32'h4);
        do_ack();
        chk("coll_clear", 32'(pending), 32'h00);
        req_n = 8'hFF;
        step(3);

`ifdef IRQ_ENCODER_MASK_EN
        // Masked line latches but stays unselectable until unmasked.
        mask_v = 8'hEF;
        req_n  = 8'hEF;
        step(4);
        chk("mask_pend", 32'(pending),   32'h10);
        chk("mask_gs_n", 32'(gs_n),      32'h1);
        chk("mask_eo_n", 32'(eo_n),      32'h0);
        chk("mask_vld",  32'(irq.valid), 32'h0);
        mask_v = 8'hFF;
        step(1);
        chk("unmask_vld",  32'(irq.valid), 32'h1);
        chk("unmask_code", 32'(irq.code),  32'h4);
        do_ack();
        req_n = 8'hFF;
        step(3);
`endif

        // Asynchronous reset in the middle of a presentation.
        req_n = 8'hDF;
        step(4);
        chk("midrst_pre_vld", 32'(irq.valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_vld",     32'(irq.valid), 32'h0);
        chk("midrst_code",    32'(irq.code),  32'h0);
        chk("midrst_pending", 32'(pending),   32'h00);
        chk("midrst_gs_n",    32'(gs_n),      32'h1);
        chk("midrst_eo_n",    32'(eo_n),      32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
